// File: rtl/serial_uart_transmitter_pkg.sv
// serial_uart_transmitter_pkg: shared types and defaults for the serial transmit path
package serial_uart_transmitter_pkg;
  localparam int SERIAL_TX_CLOCKS_PER_BIT = 543;
  localparam int SERIAL_TX_FIFO_DEPTH = 16;
  typedef logic [7:0] SerialDataPath;
  typedef logic [$clog2(SERIAL_TX_FIFO_DEPTH):0] SerialTxFifoCountPath;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} SerialTxState;
endpackage

// File: rtl/serial_tx_fifo.sv
// serial_tx_fifo: circular byte buffer with wrap-bit pointers for full/empty detection
module serial_tx_fifo
  import serial_uart_transmitter_pkg::*;
#(
  parameter int DEPTH = SERIAL_TX_FIFO_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  SerialDataPath pushData,
  input  logic pop,
  output SerialDataPath popData,
  output logic [$clog2(DEPTH):0] count,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;
  SerialDataPath mem [DEPTH];
  logic [AW:0] wrPtr, rdPtr;
  assign count = wrPtr - rdPtr;
  assign empty = wrPtr == rdPtr;
  assign full = (wrPtr[AW] != rdPtr[AW]) && (wrPtr[AW-1:0] == rdPtr[AW-1:0]);
  assign popData = mem[rdPtr[AW-1:0]];
  always_ff @(posedge clk)
    if (push) mem[wrPtr[AW-1:0]] <= pushData;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + ONE;
      if (pop) rdPtr <= rdPtr + ONE;
    end
endmodule

// File: rtl/serial_uart_transmitter.sv
// serial_uart_transmitter: FIFO-buffered 8N1 UART transmitter with sticky overflow flag
module serial_uart_transmitter
  import serial_uart_transmitter_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = SERIAL_TX_CLOCKS_PER_BIT,
  parameter int FIFO_DEPTH = SERIAL_TX_FIFO_DEPTH
) (
  input  logic clk,
  input  logic rst,
  input  logic serialWE,
  input  logic [7:0] serialWriteData,
  output logic txd,
  output logic txBusy,
  output logic fifoFull,
  output logic [$clog2(FIFO_DEPTH):0] fifoCount,
  output logic overflow
);
  SerialTxState state;
  logic [15:0] baud;
  logic [2:0] bitIdx;
  SerialDataPath shift, popData;
  logic fifoEmpty, baudDone, pop, push;
  assign baudDone = baud == 16'(CLOCKS_PER_BIT - 1);
  // A full FIFO still accepts a write when the same cycle frees a slot
  assign pop = !fifoEmpty && (state == IDLE || (state == STOP && baudDone));
  assign push = serialWE && (!fifoFull || pop);
  serial_tx_fifo #(.DEPTH(FIFO_DEPTH)) fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pushData(serialWriteData),
    .pop(pop),
    .popData(popData),
    .count(fifoCount),
    .full(fifoFull),
    .empty(fifoEmpty)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      baud <= '0;
      bitIdx <= '0;
      shift <= '0;
      txd <= 1'b1;
      txBusy <= 1'b0;
      overflow <= 1'b0;
    end else begin
      txd <= state == START ? 1'b0 : state == DATA ? shift[0] : 1'b1;
      txBusy <= state != IDLE || fifoCount != '0;
      overflow <= overflow || (serialWE && !push);
      baud <= (state == IDLE || baudDone) ? '0 : baud + 16'd1;
      case (state)
        IDLE: if (pop) begin
          shift <= popData;
          bitIdx <= '0;
          state <= START;
        end
        START: if (baudDone) begin
          bitIdx <= '0;
          state <= DATA;
        end
        DATA: if (baudDone) begin
          if (bitIdx == 3'd7) state <= STOP;
          else begin
            shift <= shift >> 1;
            bitIdx <= bitIdx + 3'd1;
          end
        end
        STOP: if (baudDone) begin
          if (pop) begin
            shift <= popData;
            bitIdx <= '0;
            state <= START;
          end else state <= IDLE;
        end
      endcase
    end
endmodule

// File: tb/tb_serial_uart_transmitter.sv
// tb_serial_uart_transmitter: timeline reference model, line receiver, table and corner-case sequences
module tb_serial_uart_transmitter;
  localparam int CPB = 4, DEPTH = 4, FRAME = 10 * CPB;
  logic clk = 0, rst = 0, serialWE = 0;
  logic [7:0] serialWriteData = 0;
  logic txd, txBusy, fifoFull, overflow;
  logic [2:0] fifoCount;
  int passed = 0, total = 0;
  always #5 clk = ~clk;

  serial_uart_transmitter #(.CLOCKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .rst(rst),
    .serialWE(serialWE),
    .serialWriteData(serialWriteData),
    .txd(txd),
    .txBusy(txBusy),
    .fifoFull(fifoFull),
    .fifoCount(fifoCount),
    .overflow(overflow)
  );

  // Model: queued bytes plus the edge at which the current frame was launched
  logic [7:0] q[$];
  int e, freeEdge, curP;
  logic [7:0] curB;
  logic mOvf, mBusy, mStateBusy;
  int rxCnt = -1;
  logic [7:0] rxByte;
  logic [7:0] rxQ[$];

  typedef struct {logic [7:0] data; logic [9:0] line;} Vec;
  Vec vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
  endtask

  function automatic logic expTxd(input int k);
    int b;
    if (k <= curP || k > curP + FRAME) return 1'b1;
    b = (k - curP - 1) / CPB;
    return b == 0 ? 1'b0 : b == 9 ? 1'b1 : curB[b-1];
  endfunction

  task automatic rxSample();
    if (rxCnt < 0) begin
      if (txd == 1'b0) rxCnt = 0;
    end else begin
      rxCnt++;
      if (rxCnt % CPB == 2 && rxCnt / CPB >= 1 && rxCnt / CPB <= 8) rxByte[rxCnt / CPB - 1] = txd;
      if (rxCnt == 9 * CPB + 2) begin
        if (txd) rxQ.push_back(rxByte);
        rxCnt = -1;
      end
    end
  endtask

  task automatic tick(input logic we, input logic [7:0] d);
    int sz;
    logic popNow;
    serialWE = we;
    serialWriteData = d;
    @(posedge clk);
    e++;
    sz = q.size();
    popNow = sz > 0 && e >= freeEdge;
    mBusy = mStateBusy || sz != 0;
    if (popNow) begin
      curB = q.pop_front();
      curP = e;
      freeEdge = e + FRAME;
    end
    if (we && (sz < DEPTH || popNow)) q.push_back(d);
    else if (we) mOvf = 1'b1;
    mStateBusy = e >= curP && e < curP + FRAME;
    @(negedge clk);
    check("model", 32'({txd, txBusy, fifoFull, fifoCount, overflow}),
          32'({expTxd(e), mBusy, q.size() == DEPTH, 3'(q.size()), mOvf}));
    rxSample();
    serialWE = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
  endtask

  task automatic doReset();
    rst = 1;
    #1;
    check("rst txd", 32'(txd), 32'(1));
    check("rst outs", 32'({txBusy, fifoFull, fifoCount, overflow}), 32'(0));
    @(posedge clk);
    @(negedge clk);
    rst = 0;
    q.delete();
    e = 0;
    freeEdge = 0;
    curP = -1000;
    mOvf = 0;
    mStateBusy = 0;
    rxCnt = -1;
  endtask

  initial begin
    logic [9:0] line;
    int lows;
    vecs[0] = '{8'hA5, 10'b1101001010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'h3C, 10'b1001111000};
    vecs[4] = '{8'h81, 10'b1100000010};
    #2;
    for (int i = 0; i < 5; i++) begin
      doReset();
      tick(1'b1, vecs[i].data);
      tick(1'b0, 8'h00);
      check("E1 txd", 32'(txd), 32'(1));
      check("E1 busy", 32'(txBusy), 32'(1));
      tick(1'b0, 8'h00);
      check("E2 txd", 32'(txd), 32'(0));
      idle(2);
      line = '0;
      line[0] = txd;
      for (int n = 1; n < 10; n++) begin
        idle(4);
        line[n] = txd;
      end
      check($sformatf("line %02h", vecs[i].data), 32'(line), 32'(vecs[i].line));
      tick(1'b0, 8'h00);
      check("E41 busy", 32'(txBusy), 32'(1));
      tick(1'b0, 8'h00);
      check("E42 busy", 32'(txBusy), 32'(0));
    end
    // back-to-back frames with no idle gap
    doReset();
    tick(1'b1, 8'h00);
    tick(1'b1, 8'hFF);
    idle(40);
    check("b2b stop", 32'(txd), 32'(1));
    tick(1'b0, 8'h00);
    check("b2b start", 32'(txd), 32'(0));
    idle(39);
    check("b2b E81 busy", 32'(txBusy), 32'(1));
    tick(1'b0, 8'h00);
    check("b2b E82 busy", 32'(txBusy), 32'(0));
    // fill to full, then one dropped write
    doReset();
    for (int i = 1; i <= 5; i++) tick(1'b1, 8'(i * 17));
    check("full flag", 32'(fifoFull), 32'(1));
    check("full count", 32'(fifoCount), 32'(4));
    check("full no ovf", 32'(overflow), 32'(0));
    tick(1'b1, 8'h66);
    check("ovf set", 32'(overflow), 32'(1));
    idle(200);
    check("ovf sticky", 32'(overflow), 32'(1));
    check("ovf drained", 32'(txBusy), 32'(0));
    // full FIFO written on the same edge as the STOP->START pop
    doReset();
    for (int i = 1; i <= 5; i++) tick(1'b1, 8'(i * 3));
    idle(36);
    check("pre-pop count", 32'(fifoCount), 32'(4));
    tick(1'b1, 8'h77);
    check("pop+push count", 32'(fifoCount), 32'(4));
    check("pop+push full", 32'(fifoFull), 32'(1));
    check("pop+push ovf", 32'(overflow), 32'(0));
    idle(200);
    // reset in the middle of a data bit
    doReset();
    tick(1'b1, 8'h3C);
    idle(12);
    check("pre-rst txd", 32'(txd), 32'(0));
    doReset();
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1'b0, 8'h00);
      if (txd == 1'b0) lows++;
    end
    check("no residual", 32'(lows), 32'(0));
    // 20 paced bytes through a wrapping FIFO, decoded by the line receiver
    doReset();
    rxQ.delete();
    for (int v = 0; v < 20; v++) begin
      for (int g = 0; g < 500 && q.size() >= DEPTH - 1; g++) tick(1'b0, 8'h00);
      tick(1'b1, 8'(v));
    end
    idle(250);
    check("rx count", 32'(rxQ.size()), 32'(20));
    for (int v = 0; v < 20 && v < rxQ.size(); v++) check($sformatf("rx byte %0d", v), 32'(rxQ[v]), 32'(v));
    // random traffic against the model
    doReset();
    for (int i = 0; i < 1500; i++) begin
      if (i % 500 < 400) tick($urandom_range(0, 9) == 0, 8'($urandom));
      else tick($urandom_range(0, 1) == 0, 8'($urandom));
    end
    idle(250);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
